// File: rtl/mac_result_drain_pkg.sv
// Shared constants for the MAC result drain: precision modes, default sizes,
// the drain FSM encoding and the mode-to-lane-count mapping.
package mac_result_drain_pkg;

  localparam int MAC_ACC_WIDTH   = 32;
  localparam int MAC_DRAIN_DEPTH = 2;

  localparam logic [1:0] MAC_MODE_SINGLE = 2'b00;
  localparam logic [1:0] MAC_MODE_DUAL   = 2'b01;
  localparam logic [1:0] MAC_MODE_QUAD   = 2'b10;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_STREAM = 1'b1
  } drain_state_t;

  // Reserved mode 11 falls through to the full four-word set.
  function automatic logic [2:0] mac_lane_count(input logic [1:0] mode);
    case (mode)
      MAC_MODE_DUAL: return 3'd2;
      MAC_MODE_QUAD: return 3'd1;
      default:       return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mac_result_drain_fifo.sv
// Generic synchronous FIFO (module mac_drain_fifo) holding captured result sets.
// Pointers carry one wrap bit above the index so full and empty are unambiguous.
module mac_drain_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign count   = wr_ptr_reg - rd_ptr_reg;
  // A full FIFO refuses a push even when the head leaves in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mac_result_drain.sv
// Captures MAC cluster result sets and serialises their valid lanes onto one
// valid/ready stream. Define MAC_DRAIN_LANE_TAG_EN to add m_lane/m_mode outputs.
module mac_result_drain
  import mac_result_drain_pkg::*;
#(
  parameter int ACC_W = MAC_ACC_WIDTH,
  parameter int DEPTH = MAC_DRAIN_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_valid,
  input  logic [1:0]       cap_mode,
  input  logic [ACC_W-1:0] in0,
  input  logic [ACC_W-1:0] in1,
  input  logic [ACC_W-1:0] in2,
  input  logic [ACC_W-1:0] in3,
  output logic             cap_ready,
  output logic [ACC_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
`ifdef MAC_DRAIN_LANE_TAG_EN
  output logic [1:0]       m_lane,
  output logic [1:0]       m_mode,
`endif
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
`ifdef MAC_DRAIN_LANE_TAG_EN
  localparam int ENTRY_W = 4*ACC_W + 5;
`else
  localparam int ENTRY_W = 4*ACC_W + 3;
`endif

  drain_state_t     state_reg;
  logic [1:0]       lane_reg;
  logic             overflow_reg;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_set;
  logic [2:0]       head_cnt;
  logic [ACC_W-1:0] head_word [4];

`ifdef MAC_DRAIN_LANE_TAG_EN
  assign push_data = {cap_mode, mac_lane_count(cap_mode), in3, in2, in1, in0};
  assign m_lane    = empty ? 2'd0 : lane_reg;
  assign m_mode    = empty ? 2'd0 : head[4*ACC_W+3 +: 2];
`else
  assign push_data = {mac_lane_count(cap_mode), in3, in2, in1, in0};
`endif

  mac_drain_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cap_valid),
    .push_data (push_data),
    .pop       (pop_set),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
      assign head_word[gi] = head[gi*ACC_W +: ACC_W];
    end
  endgenerate

  assign head_cnt  = head[4*ACC_W +: 3];
  assign cap_ready = !full;
  assign push_ok   = cap_valid && !full;
  assign m_valid   = (state_reg == ST_STREAM);
  assign m_data    = empty ? '0 : head_word[lane_reg];
  assign m_last    = m_valid && ({1'b0, lane_reg} == (head_cnt - 3'd1));
  assign pop_set   = m_valid && m_ready && m_last;
  assign overflow  = overflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_EMPTY;
      lane_reg     <= 2'd0;
      overflow_reg <= 1'b0;
    end else begin
      if (cap_valid && full) overflow_reg <= 1'b1;
      if (m_valid && m_ready) lane_reg <= m_last ? 2'd0 : lane_reg + 2'd1;
      case (state_reg)
        ST_EMPTY:  if (push_ok) state_reg <= ST_STREAM;
        ST_STREAM: if (pop_set && !push_ok && count == {{AW{1'b0}}, 1'b1})
                     state_reg <= ST_EMPTY;
        default:   state_reg <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: doc/mac_result_drain.md
Name: mac_result_drain

Overview:
- Sits directly downstream of the MAC quad-cluster.
- Captures the cluster's four accumulator outputs (out0..out3) as one result set, buffers sets in a small FIFO, and serialises the valid lanes onto a single valid/ready stream toward the fabric/readback path.
- Mode-aware: emits 4, 2 or 1 words per set for single, dual or quad precision.
- Its cap_ready back-pressures the cluster's en.

Parameters:
- ACC_W, default `MAC_ACC_WIDTH: width of each result word.
- DEPTH, default 2: result sets buffered; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cap_valid  in  1  cluster result set valid this cycle.
- cap_mode  in  2  precision mode of the set: 00 single, 01 dual, 10 quad, 11 reserved.
- in0  in  ACC_W  cluster out0.
- in1  in  ACC_W  cluster out1.
- in2  in  ACC_W  cluster out2.
- in3  in  ACC_W  cluster out3.
- cap_ready  out  1  FIFO can accept a set; drives the cluster en.
- m_data  out  ACC_W  current output word.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts the word.
- m_last  out  1  m_data is the final word of its set.
- overflow  out  1  sticky: cap_valid was seen while cap_ready was low.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - FIFO emptied; lane index = 0.
  - m_valid = 0, m_last = 0, m_data = 0, overflow = 0, cap_ready = 1.
  - Reset mid-stream discards all buffered sets and any partial set.
- Capture:
  - A push occurs when cap_valid && cap_ready.
  - It stores {in0..in3, lane count}.
  - Lane count: 00 → 4; 01 → 2 (in0, in1); 10 → 1 (in0); 11 → treated as 4.
- cap_ready:
  - cap_ready = !full, combinational from registered state only.
  - No bypass: when full, a push is refused even if the final word pops in the same cycle.
  - cap_valid && !cap_ready sets overflow; only rst clears it.
- Output:
  - m_valid = !empty.
  - m_data = head set word[lane index], or 0 when empty.
  - m_last = m_valid && (lane index == head lane count − 1).
- Pop:
  - On m_valid && m_ready: if m_last, pop the head and set lane index to 0; otherwise increment lane index.
  - m_valid && !m_ready holds m_data, m_last and the lane index stable (AXI-style).
  - m_valid never drops without a handshake.
- Latency: a set captured at edge N presents word 0 with m_valid high during cycle N+1.
- Throughput: 1 word per cycle when m_ready is held high.
  - Single mode: 4 cycles per set.
  - Quad mode: 1 set per cycle, sustained if DEPTH ≥ 2.
- Simultaneous push and pop (not full): both take effect; occupancy is unchanged.
- Pointer wrap: pointers are log2(DEPTH) bits plus one wrap bit; full = same index with opposite wrap bit.
- State machine, two states:
  - EMPTY → STREAM on push.
  - STREAM → EMPTY on a final-word pop with no concurrent push and occupancy 1.
  - Otherwise stay in STREAM.

Optional Feature:
- Macro: MAC_DRAIN_LANE_TAG_EN.
- Defined:
  - Extra output port m_lane, out, 2 bits: the lane index of the current word.
  - Extra output port m_mode, out, 2 bits: the head set's stored mode (11 reported as captured).
  - Both ports are 0 when empty and are held under stall like m_data.
- Undefined: neither port exists; all other behaviour is identical.

Decomposition:
- Additions to mac_const.vh:
  - MAC_MODE_SINGLE = 2'b00, MAC_MODE_DUAL = 2'b01, MAC_MODE_QUAD = 2'b10.
  - MAC_DRAIN_DEPTH default.
  - A lane-count function/macro mapping mode to lane count.
- Sub-module mac_drain_fifo: a generic synchronous FIFO (push, pop, full, empty, head data) of width 4*ACC_W+3, instantiated once.
- Lane counter and serialiser live in the top module.

Test Plan:
- Reset then idle → cap_ready = 1, m_valid = 0, overflow = 0 for 10 cycles.
- Single mode: in0..in3 = 0x11, 0x22, 0x33, 0x44, m_ready held 1 → m_data 0x11, 0x22, 0x33, 0x44 on cycles N+1..N+4; m_last only on 0x44.
- Quad mode: 3 sets back-to-back (in0 = 0xA, 0xB, 0xC), m_ready = 1 → 3 words each with m_last = 1; cap_ready never drops.
- Dual mode: in0 = 5, in1 = 6, in2/in3 = 0xFF; m_ready toggles 1, 0, 1 → words 5, 6 only; m_data held during the stall; 0xFF never emitted.
- Fill: m_ready = 0, push DEPTH single-mode sets → cap_ready = 0; a further cap_valid sets overflow = 1; then m_ready = 1 drains 4·DEPTH words in order, and overflow stays 1.
- Reset mid-stream after word 2 of a set → next cycle m_valid = 0 and cap_ready = 1; a new set streams starting from its word 0.
